product_accumulator: RTL and testbench

//  Downstream stage of the 2x2 multiplier: consumes its 4-bit products (q3..q0 packed as prod[3:0]).

---
 rtl/product_accumulator_if.sv | 23 ++
 rtl/product_accumulator.sv | 104 ++++++++++
 tb/tb_product_accumulator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input stream and accumulated result stream bundle
interface product_accumulator_if #(
  parameter int PROD_W = 4,
  parameter int ACC_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;

  modport master (
    output in_valid, prod, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, prod, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums COUNT multiplier products per result; MAC_SAT_EN selects saturation
module product_accumulator #(
  parameter int PROD_W = 4,
  parameter int COUNT  = 4,
  parameter int ACC_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  product_accumulator_if.slave  bus
);
  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base, acc_add;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             accept;
  logic             consume;

  assign bus.in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.acc_out   = acc_q;

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = (state_q == DONE) & bus.out_ready;

  // The first product of a result starts from zero rather than the held accumulator.
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;
  assign cnt_inc  = ((state_q == IDLE) ? '0 : cnt_q) + CNT_W'(1);

`ifdef MAC_SAT_EN
  localparam int SUM_W = ACC_W + 1;
  logic [ACC_W:0] sum;
  logic           ovf_q;

  assign sum     = {1'b0, acc_base} + SUM_W'(bus.prod);
  assign acc_add = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign bus.ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (clr || consume) begin
      ovf_q <= 1'b0;
    end else if (accept && sum[ACC_W]) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign acc_add = acc_base + ACC_W'(bus.prod);
  assign bus.ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_d   = acc_add;
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CNT_W'(COUNT)) ? DONE : ACC;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator (ACC_W=8 and ACC_W=5 instances)
module tb_product_accumulator;
  localparam int COUNT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_a, clr_b;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(4), .ACC_W(8)) a ();
  product_accumulator_if #(.PROD_W(4), .ACC_W(5)) b ();

  product_accumulator #(.PROD_W(4), .COUNT(COUNT), .ACC_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(a)
  );
  product_accumulator #(.PROD_W(4), .COUNT(COUNT), .ACC_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .bus(b)
  );

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  int sum_a = 0, n_a = 0, sum_b = 0, n_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {ovf, acc} for a result whose products add up to total.
  function automatic logic [8:0] model(input int total, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef MAC_SAT_EN
    if (total > mx) return {1'b1, 8'(mx)};
    return {1'b0, 8'(total)};
`else
    return {1'b0, 8'(total % (mx + 1))};
`endif
  endfunction

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && !clr_a && a.out_valid && a.out_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_result_acc", a.acc_out, e[7:0]);
        chk("a_result_ovf", a.ovf, e[8]);
      end
    end
    if (!rst_n || clr_a) begin
      sum_a = 0; n_a = 0; q_a.delete();
    end else if (a.in_valid && a.in_ready) begin
      sum_a += a.prod; n_a++;
      if (n_a == COUNT) begin q_a.push_back(model(sum_a, 8)); sum_a = 0; n_a = 0; end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && !clr_b && b.out_valid && b.out_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_result_acc", b.acc_out, e[4:0]);
        chk("b_result_ovf", b.ovf, e[8]);
      end
    end
    if (!rst_n || clr_b) begin
      sum_b = 0; n_b = 0; q_b.delete();
    end else if (b.in_valid && b.in_ready) begin
      sum_b += b.prod; n_b++;
      if (n_b == COUNT) begin q_b.push_back(model(sum_b, 5)); sum_b = 0; n_b = 0; end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_a(input logic [3:0] p);
    int n; logic took;
    a.in_valid = 1'b1; a.prod = p; n = 0; took = 1'b0;
    while (!took && n < 50) begin
      @(negedge clk); took = a.in_ready;
      @(posedge clk); #1; n++;
    end
    a.in_valid = 1'b0;
    if (!took) chk("send_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    a.in_valid = 1'b0; a.prod = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.prod = '0; b.out_ready = 1'b0;
    cyc(2);
    chk("reset_out_valid", a.out_valid, 0);
    chk("reset_in_ready", a.in_ready, 1);
    chk("reset_acc_out", a.acc_out, 0);
    chk("reset_ovf", a.ovf, 0);
    rst_n = 1'b1;
    cyc(1);

    // back-to-back products, then hold the result under backpressure
    send_a(3); send_a(6); send_a(9);
    chk("s1_not_valid_early", a.out_valid, 0);
    send_a(2);
    chk("s1_out_valid", a.out_valid, 1);
    chk("s1_acc_out", a.acc_out, 20);
    chk("s1_ovf", a.ovf, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("s2_hold_valid", a.out_valid, 1);
      chk("s2_hold_acc", a.acc_out, 20);
      chk("s2_hold_in_ready", a.in_ready, 0);
    end
    a.out_ready = 1'b1;
    cyc(1);
    chk("s2_released_valid", a.out_valid, 0);
    chk("s2_released_acc", a.acc_out, 0);
    chk("s2_released_in_ready", a.in_ready, 1);

    // gaps in in_valid
    a.out_ready = 1'b0;
    send_a(1); cyc(2); send_a(4); cyc(1); send_a(9); send_a(1);
    chk("s3_out_valid", a.out_valid, 1);
    chk("s3_acc_out", a.acc_out, 15);
    cyc(2);
    chk("s3_no_extra", a.acc_out, 15);
    a.out_ready = 1'b1;
    cyc(1);

    // narrow accumulator overflow
    b.in_valid = 1'b1; b.prod = 4'd9;
    cyc(4);
    b.in_valid = 1'b0;
    chk("s4_out_valid", b.out_valid, 1);
`ifdef MAC_SAT_EN
    chk("s4_acc_out", b.acc_out, 31);
    chk("s4_ovf", b.ovf, 1);
`else
    chk("s4_acc_out", b.acc_out, 4);
    chk("s4_ovf", b.ovf, 0);
`endif
    b.out_ready = 1'b1;
    cyc(1);
    chk("s4_released", b.out_valid, 0);

    // clear a partial sum, then reset while a result is pending
    send_a(9); send_a(9);
    clr_a = 1'b1; cyc(1); clr_a = 1'b0;
    chk("s5_clr_acc", a.acc_out, 0);
    chk("s5_clr_in_ready", a.in_ready, 1);
    a.out_ready = 1'b0;
    send_a(1); send_a(1); send_a(1); send_a(1);
    chk("s5_acc_out", a.acc_out, 4);
    chk("s5_out_valid", a.out_valid, 1);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    chk("s5_rst_valid", a.out_valid, 0);
    chk("s5_rst_acc", a.acc_out, 0);

    // in_valid presented while DONE is consumed
    send_a(4'($urandom_range(0, 15))); send_a(4'($urandom_range(0, 15)));
    send_a(4'($urandom_range(0, 15))); send_a(4'($urandom_range(0, 15)));
    a.in_valid = 1'b1; a.prod = 4'd5; a.out_ready = 1'b1;
    cyc(1);
    chk("s6_not_taken_valid", a.out_valid, 0);
    chk("s6_not_taken_acc", a.acc_out, 0);
    cyc(1);
    a.in_valid = 1'b0;
    chk("s6_taken_acc", a.acc_out, 5);
    chk("s6_taken_valid", a.out_valid, 0);
    send_a(4'($urandom_range(0, 15))); send_a(4'($urandom_range(0, 15))); send_a(4'($urandom_range(0, 15)));
    chk("s6_done_after_three", a.out_valid, 1);
    cyc(2);

    // randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      a.in_valid  = ($urandom_range(0, 2) != 0);
      a.prod      = 4'($urandom_range(0, 15));
      a.out_ready = 1'($urandom_range(0, 1));
      clr_a       = ($urandom_range(0, 63) == 0);
      b.in_valid  = ($urandom_range(0, 2) != 0);
      b.prod      = 4'($urandom_range(0, 15));
      b.out_ready = 1'($urandom_range(0, 1));
      clr_b       = ($urandom_range(0, 63) == 0);
      cyc(1);
    end
    clr_a = 1'b0; clr_b = 1'b0;
    a.in_valid = 1'b0; b.in_valid = 1'b0;
    a.out_ready = 1'b1; b.out_ready = 1'b1;
    cyc(10);
    chk("a_scoreboard_drained", q_a.size(), 0);
    chk("b_scoreboard_drained", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
